// File: rtl/i2c_bit_phase_ctrl.sv
// I2C master bit-phase controller: runs START/STOP/BIT commands as four quarter-bit phases.
// Optional slave-stretch abort is built when I2C_STRETCH_TIMEOUT_EN is defined.
module i2c_bit_phase_ctrl #(
    parameter int STRETCH_TIMEOUT_TICKS = 1024,
    parameter int TO_CNT_BITS           = 11
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       enable,
    input  logic       tick,
    input  logic       cmd_valid,
    input  logic [1:0] cmd,
    input  logic       tx_bit,
    output logic       cmd_ready,
    output logic       done,
    output logic       rx_bit,
    output logic       arb_lost,
    output logic       timeout,
    input  logic       scl_in,
    input  logic       sda_in,
    output logic       scl_oe,
    output logic       sda_oe
);

    typedef enum logic [2:0] {
        IDLE,
        NOP_W,
        Q0,
        Q1,
        Q2,
        Q3
    } state_t;

    localparam logic [1:0] CMD_START = 2'b00;
    localparam logic [1:0] CMD_STOP  = 2'b01;
    localparam logic [1:0] CMD_BIT   = 2'b10;

    state_t     state;
    state_t     state_nxt;
    logic [1:0] cmd_q;
    logic       tx_q;
    logic       scl_meta;
    logic       scl_s;
    logic       sda_meta;
    logic       sda_s;
    logic [1:0] lines_nxt;
    logic       done_nxt;
    logic       rx_nxt;
    logic       arb_nxt;
    logic       accept;

    // Line enables {scl_oe, sda_oe} for a command in a given quarter phase.
    function automatic logic [1:0] line_val(input logic [1:0] c, input logic tx,
                                            input logic [1:0] ph);
        logic [1:0] v;
        v = 2'b00;
        case (c)
            CMD_START: begin
                case (ph)
                    2'd0, 2'd1: v = 2'b00;
                    2'd2:       v = 2'b01;
                    default:    v = 2'b11;
                endcase
            end
            CMD_STOP: begin
                case (ph)
                    2'd0:       v = 2'b11;
                    2'd1, 2'd2: v = 2'b01;
                    default:    v = 2'b00;
                endcase
            end
            CMD_BIT: v = {(ph == 2'd0) || (ph == 2'd3), ~tx};
            default: v = 2'b00;
        endcase
        return v;
    endfunction

    assign cmd_ready = (state == IDLE) && enable;
    assign accept    = cmd_valid && cmd_ready;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            scl_meta <= 1'b1;
            scl_s    <= 1'b1;
            sda_meta <= 1'b1;
            sda_s    <= 1'b1;
        end else begin
            scl_meta <= scl_in;
            scl_s    <= scl_meta;
            sda_meta <= sda_in;
            sda_s    <= sda_meta;
        end
    end

    always_ff @(posedge clk) begin
        if (accept) begin
            cmd_q <= cmd;
            tx_q  <= tx_bit;
        end
    end

`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam logic [TO_CNT_BITS-1:0] TO_LIMIT = TO_CNT_BITS'(STRETCH_TIMEOUT_TICKS);

    logic [TO_CNT_BITS-1:0] to_cnt;
    logic                   to_hit;
    logic                   to_nxt;

    assign to_hit = (to_cnt == TO_LIMIT);

    // Counts only ticks swallowed while the slave holds SCL low in Q1.
    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            to_cnt <= '0;
        end else if (state == Q0 && state_nxt == Q1) begin
            to_cnt <= '0;
        end else if (state == Q1 && state_nxt == Q1 && tick && !scl_s) begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            timeout <= 1'b0;
        end else begin
            timeout <= to_nxt;
        end
    end
`else
    assign timeout = 1'b0;
`endif

    always_comb begin
        state_nxt = state;
        lines_nxt = {scl_oe, sda_oe};
        done_nxt  = 1'b0;
        rx_nxt    = rx_bit;
        arb_nxt   = 1'b0;
`ifdef I2C_STRETCH_TIMEOUT_EN
        to_nxt    = 1'b0;
`endif
        if (!enable) begin
            state_nxt = IDLE;
            lines_nxt = 2'b00;
        end else begin
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        if (cmd == 2'b11) begin
                            state_nxt = NOP_W;
                        end else begin
                            state_nxt = Q0;
                            lines_nxt = line_val(cmd, tx_bit, 2'd0);
                        end
                    end
                end
                NOP_W: begin
                    state_nxt = IDLE;
                    done_nxt  = 1'b1;
                end
                Q0: begin
                    if (tick) begin
                        state_nxt = Q1;
                        lines_nxt = line_val(cmd_q, tx_q, 2'd1);
                    end
                end
                Q1: begin
`ifdef I2C_STRETCH_TIMEOUT_EN
                    if (to_hit) begin
                        state_nxt = IDLE;
                        lines_nxt = 2'b00;
                        to_nxt    = 1'b1;
                    end else
`endif
                    if (tick && scl_s) begin
                        state_nxt = Q2;
                        lines_nxt = line_val(cmd_q, tx_q, 2'd2);
                        if (cmd_q == CMD_BIT) begin
                            rx_nxt = sda_s;
                        end
                    end
                end
                Q2: begin
                    if (tick) begin
                        state_nxt = Q3;
                        lines_nxt = line_val(cmd_q, tx_q, 2'd3);
                    end
                end
                Q3: begin
                    if (tick) begin
                        state_nxt = IDLE;
                        done_nxt  = 1'b1;
                        // rx_bit already holds this command's sample here.
                        arb_nxt   = (cmd_q == CMD_BIT) && tx_q && !rx_bit;
                    end
                end
                default: begin
                    state_nxt = IDLE;
                    lines_nxt = 2'b00;
                end
            endcase
        end
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state    <= IDLE;
            scl_oe   <= 1'b0;
            sda_oe   <= 1'b0;
            done     <= 1'b0;
            rx_bit   <= 1'b0;
            arb_lost <= 1'b0;
        end else begin
            state    <= state_nxt;
            scl_oe   <= lines_nxt[1];
            sda_oe   <= lines_nxt[0];
            done     <= done_nxt;
            rx_bit   <= rx_nxt;
            arb_lost <= arb_nxt;
        end
    end

endmodule

// File: tb/tb_i2c_bit_phase_ctrl.sv
// Directed self-checking bench for i2c_bit_phase_ctrl with an open-drain bus model.
module tb_i2c_bit_phase_ctrl;

`ifdef I2C_STRETCH_TIMEOUT_EN
    localparam int TO_TICKS = 4;
`else
    localparam int TO_TICKS = 1024;
`endif

    logic       clk = 1'b0;
    logic       n_rst;
    logic       enable;
    logic       tick;
    logic       cmd_valid;
    logic [1:0] cmd;
    logic       tx_bit;
    logic       cmd_ready;
    logic       done;
    logic       rx_bit;
    logic       arb_lost;
    logic       timeout;
    logic       scl_in;
    logic       sda_in;
    logic       scl_oe;
    logic       sda_oe;
    logic       scl_hold;
    logic       sda_force0;
    int         cyc_cnt = 0;
    int         n_checks = 0;
    int         n_errors = 0;

    always #5 clk = ~clk;
    always @(posedge clk) cyc_cnt <= cyc_cnt + 1;

    // Wired-AND bus: a line is high only if nobody pulls it low.
    assign scl_in = ~scl_oe & ~scl_hold;
    assign sda_in = ~sda_oe & ~sda_force0;

    i2c_bit_phase_ctrl #(
        .STRETCH_TIMEOUT_TICKS(TO_TICKS),
        .TO_CNT_BITS(11)
    ) dut (
        .clk(clk),
        .n_rst(n_rst),
        .enable(enable),
        .tick(tick),
        .cmd_valid(cmd_valid),
        .cmd(cmd),
        .tx_bit(tx_bit),
        .cmd_ready(cmd_ready),
        .done(done),
        .rx_bit(rx_bit),
        .arb_lost(arb_lost),
        .timeout(timeout),
        .scl_in(scl_in),
        .sda_in(sda_in),
        .scl_oe(scl_oe),
        .sda_oe(sda_oe)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s act=%0h exp=%0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic do_tick();
        tick = 1'b1;
        cyc();
        tick = 1'b0;
    endtask

    task automatic accept_cmd(input logic [1:0] c, input logic tx);
        cmd_valid = 1'b1;
        cmd       = c;
        tx_bit    = tx;
        tick      = 1'b1;
        cyc();
        cmd_valid = 1'b0;
        tick      = 1'b0;
    endtask

    // exp packs {scl_oe,sda_oe} for Q0..Q3, Q0 in the top two bits.
    task automatic run_cmd(input string tag, input logic [1:0] c, input logic tx,
                           input logic [7:0] exp);
        int t0;
        accept_cmd(c, tx);
        t0 = cyc_cnt;
        chk($sformatf("%s_q0", tag), 32'({scl_oe, sda_oe}), 32'(exp[7:6]));
        chk($sformatf("%s_busy", tag), 32'(cmd_ready), 32'd0);
        for (int p = 1; p < 4; p++) begin
            repeat (4) cyc();
            do_tick();
            chk($sformatf("%s_q%0d", tag, p), 32'({scl_oe, sda_oe}), 32'(exp[7-2*p -: 2]));
        end
        repeat (4) cyc();
        chk($sformatf("%s_early", tag), 32'(done), 32'd0);
        do_tick();
        chk($sformatf("%s_done", tag), 32'(done), 32'd1);
        chk($sformatf("%s_lat", tag), 32'(cyc_cnt - t0), 32'd20);
    endtask

    initial begin
        n_rst      = 1'b0;
        enable     = 1'b0;
        tick       = 1'b0;
        cmd_valid  = 1'b0;
        cmd        = 2'b11;
        tx_bit     = 1'b0;
        scl_hold   = 1'b0;
        sda_force0 = 1'b0;
        repeat (3) cyc();
        chk("rst_lines", 32'({scl_oe, sda_oe}), 32'd0);
        chk("rst_flags", 32'({done, rx_bit, arb_lost, timeout}), 32'd0);
        chk("rst_ready_dis", 32'(cmd_ready), 32'd0);
        n_rst  = 1'b1;
        enable = 1'b1;
        cyc();
        chk("rst_ready", 32'(cmd_ready), 32'd1);

        run_cmd("start", 2'b00, 1'b0, 8'b00_00_01_11);
        cyc();
        chk("start_hold", 32'({done, scl_oe, sda_oe}), 32'b011);

        run_cmd("bit0", 2'b10, 1'b0, 8'b11_01_01_11);
        chk("bit0_rx", 32'({rx_bit, arb_lost}), 32'b00);
        cyc();
        run_cmd("bit1", 2'b10, 1'b1, 8'b10_00_00_10);
        chk("bit1_rx", 32'({rx_bit, arb_lost}), 32'b10);
        cyc();
        chk("bit1_pulse", 32'({done, arb_lost}), 32'b00);

        sda_force0 = 1'b1;
        run_cmd("arb", 2'b10, 1'b1, 8'b10_00_00_10);
        chk("arb_rx", 32'({rx_bit, arb_lost}), 32'b01);
        cyc();
        chk("arb_pulse", 32'({done, arb_lost, rx_bit}), 32'b000);
        sda_force0 = 1'b0;

        run_cmd("stop", 2'b01, 1'b0, 8'b11_01_01_00);
        cyc();

`ifndef I2C_STRETCH_TIMEOUT_EN
        begin
            int t0;
            accept_cmd(2'b00, 1'b0);
            t0 = cyc_cnt;
            scl_hold = 1'b1;
            repeat (4) cyc();
            do_tick();
            chk("str_q1", 32'({scl_oe, sda_oe}), 32'b00);
            for (int i = 0; i < 7; i++) begin
                repeat (4) cyc();
                do_tick();
                chk($sformatf("str_drop%0d", i), 32'({scl_oe, sda_oe, done}), 32'b000);
            end
            scl_hold = 1'b0;
            repeat (4) cyc();
            do_tick();
            chk("str_q2", 32'({scl_oe, sda_oe}), 32'b01);
            repeat (4) cyc();
            do_tick();
            chk("str_q3", 32'({scl_oe, sda_oe}), 32'b11);
            repeat (4) cyc();
            do_tick();
            chk("str_done", 32'(done), 32'd1);
            chk("str_lat", 32'(cyc_cnt - t0), 32'd55);
            cyc();
        end
`endif

        accept_cmd(2'b10, 1'b0);
        repeat (2) begin
            repeat (4) cyc();
            do_tick();
        end
        chk("en_q2", 32'({scl_oe, sda_oe}), 32'b01);
        enable = 1'b0;
        cyc();
        chk("en_abort", 32'({scl_oe, sda_oe, done, cmd_ready}), 32'b0000);
        enable = 1'b1;
        #1;
        chk("en_ready", 32'(cmd_ready), 32'd1);
        for (int i = 0; i < 3; i++) begin
            repeat (4) cyc();
            do_tick();
            chk($sformatf("en_nodone%0d", i), 32'({done, scl_oe, sda_oe}), 32'b000);
        end

        accept_cmd(2'b11, 1'b0);
        chk("nop_acc", 32'({done, cmd_ready}), 32'b00);
        cyc();
        chk("nop_done", 32'({done, scl_oe, sda_oe}), 32'b100);
        cyc();
        chk("nop_end", 32'({done, cmd_ready}), 32'b01);

        accept_cmd(2'b10, 1'b0);
        repeat (4) cyc();
        do_tick();
        chk("ar_q1", 32'({scl_oe, sda_oe}), 32'b01);
        #3;
        n_rst = 1'b0;
        #1;
        chk("ar_lines", 32'({scl_oe, sda_oe, done}), 32'b000);
        cyc();
        n_rst = 1'b1;
        repeat (3) begin
            repeat (4) cyc();
            do_tick();
        end
        chk("ar_idle", 32'({done, cmd_ready, scl_oe, sda_oe}), 32'b0100);

`ifdef I2C_STRETCH_TIMEOUT_EN
        accept_cmd(2'b10, 1'b0);
        scl_hold = 1'b1;
        repeat (4) cyc();
        do_tick();
        chk("to_q1", 32'({scl_oe, sda_oe}), 32'b01);
        for (int i = 0; i < 4; i++) begin
            repeat (4) cyc();
            do_tick();
            chk($sformatf("to_wait%0d", i), 32'({timeout, sda_oe}), 32'b01);
        end
        cyc();
        chk("to_pulse", 32'({timeout, done, scl_oe, sda_oe}), 32'b1000);
        cyc();
        chk("to_end", 32'({timeout, cmd_ready}), 32'b01);
        scl_hold = 1'b0;
`else
        chk("to_tied", 32'(timeout), 32'd0);
`endif

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
